// File: rtl/srp_pkg.sv
// Shared constants and state encoding for the SRP sample-buffer capture path.
`timescale 1ns/1ps
package srp_pkg;

    localparam int unsigned SRP_DEPTH = 2240;
    localparam int unsigned SRP_AW    = 12;
    localparam int unsigned SRP_DW    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFull
    } srp_state_e;

endpackage

// File: rtl/srp_capture_ctrl.sv
// Fills the single-port SRP sample buffer, then hands its port to the correlator for reads.
// Optional SRP_CAPTURE_OVF_CNT_EN adds a saturating dropped-sample counter (ovf_cnt).
`timescale 1ns/1ps
module srp_capture_ctrl
    import srp_pkg::*;
#(
    parameter int unsigned DEPTH = SRP_DEPTH,
    parameter int unsigned AW    = SRP_AW,
    parameter int unsigned DW    = SRP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          cont,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_done,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    output logic          frame_done,
`ifdef SRP_CAPTURE_OVF_CNT_EN
    output logic [15:0]   ovf_cnt,
`endif
    output logic          buf_full
);

    srp_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          frame_done_q, frame_done_d;
    logic          wr_fire;
    logic          wr_last;

    assign wr_fire = (state_q == StFill) && s_valid;
    assign wr_last = wr_fire && (wr_ptr_q == AW'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        frame_done_d = wr_last;
        unique case (state_q)
            StIdle: begin
                if (arm) state_d = StFill;
            end
            StFill: begin
                if (wr_last) state_d = StFull;
            end
            StFull: begin
                // cont only matters at the release cycle
                if (rd_done) state_d = cont ? StFill : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Pointer only moves in FILL; holding it at zero elsewhere keeps every fill starting at 0
        if (state_q != StFill) begin
            wr_ptr_d = '0;
        end else if (wr_fire) begin
            wr_ptr_d = wr_last ? '0 : wr_ptr_q + AW'(1);
        end
    end

    // Output logic: BRAM port mux keyed on state
    always_comb begin
        s_ready   = 1'b0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_di   = '0;
        buf_full  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StFill: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    bram_en   = 1'b1;
                    bram_we   = 1'b1;
                    bram_addr = wr_ptr_q;
                    bram_di   = s_data;
                end
            end
            StFull: begin
                buf_full  = 1'b1;
                bram_en   = rd_en;
                bram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign frame_done = frame_done_q;

`ifdef SRP_CAPTURE_OVF_CNT_EN
    logic [15:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == StIdle) && arm) begin
            ovf_d = '0;
        end else if (s_valid && !s_ready && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_cnt = ovf_q;
`endif

    // Pointer stays inside the buffer and writes only happen while filling
    a_ptr_bound: assert property (@(posedge clk) disable iff (!rst_n) wr_ptr_q < AW'(DEPTH));
    a_we_fill:   assert property (@(posedge clk) disable iff (!rst_n) bram_we |-> state_q == StFill);

endmodule
